// File: rtl/freq_sweeper_gen2.sv
// freq_sweeper_gen2: DDS tuning-word controller with up/down/triangle sweeps and shift-based PI PLL tracking.
// Latency: accept -> one SETUP cycle -> init_freq on dds_freq the cycle after; each PI result lands one cycle after its sample.
// Backpressure: instr_ready is high only in IDLE, so the FIFO word waits until the current sweep ends or is aborted.
module freq_sweeper_gen2 #(
  parameter int FREQ_W      = 32,
  parameter int CYC_W       = 16,
  parameter int NSTEP_W     = 12,
  parameter int ERR_W       = 16,
  parameter int KP_SHIFT    = 3,
  parameter int KI_SHIFT    = 1,
  parameter int LOCK_CYCLES = 1024,
  parameter int TRACK_DIV   = 16,
  parameter int LOCK_TOL    = 64
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [2+2*FREQ_W+CYC_W+NSTEP_W-1:0] instr_data,
  input  logic                                instr_valid,
  output logic                                instr_ready,
  input  logic                                abort,
  input  logic [ERR_W-1:0]                    phase_error,
  output logic [FREQ_W-1:0]                   dds_freq,
  output logic                                freq_update,
  output logic                                sweep_start,
  output logic                                sweep_done,
  output logic                                pll_enable,
  output logic                                pll_locked,
  output logic                                busy
);

  // Field positions inside the instruction word, LSB first.
  localparam int NS_LSB   = FREQ_W;
  localparam int CPS_LSB  = FREQ_W + NSTEP_W;
  localparam int INIT_LSB = FREQ_W + NSTEP_W + CYC_W;
  localparam int MODE_LSB = 2 * FREQ_W + NSTEP_W + CYC_W;

  // One counter serves both the lock settle time and the tracking divider.
  localparam int PCNT_MAX = (LOCK_CYCLES > TRACK_DIV) ? LOCK_CYCLES : TRACK_DIV;
  localparam int PCNT_W   = $clog2(PCNT_MAX) + 1;

  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_TRI  = 2'b10;
  localparam logic [1:0] MODE_PLL  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SWEEP,
    S_PLL_LOCK,
    S_PLL_TRACK
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [FREQ_W-1:0]  init_q, init_d;
  logic [FREQ_W-1:0]  step_q, step_d;
  logic [FREQ_W-1:0]  dds_q, dds_d;
  logic [FREQ_W-1:0]  integ_q, integ_d;
  logic [CYC_W-1:0]   cps_q, cps_d;
  logic [CYC_W-1:0]   dwell_q, dwell_d;
  logic [NSTEP_W-1:0] nsteps_q, nsteps_d;
  logic [NSTEP_W-1:0] stepcnt_q, stepcnt_d;
  logic               descend_q, descend_d;
  logic [PCNT_W-1:0]  pcnt_q, pcnt_d;
  logic [2:0]         good_q, good_d;
  logic               upd_q, upd_d;
  logic               start_q, start_d;
  logic               done_q, done_d;
  logic               ena_q, ena_d;
  logic               locked_q, locked_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;

  logic [CYC_W-1:0]   dwell_last;
  logic               going_down;
  logic [FREQ_W-1:0]  err_ext;
  logic [FREQ_W-1:0]  kp_term;
  logic [FREQ_W-1:0]  ki_term;
  logic [FREQ_W:0]    integ_sum;
  logic [FREQ_W-1:0]  integ_sat;
  logic [FREQ_W-1:0]  pi_freq;
  logic [ERR_W:0]     err_sx;
  logic [ERR_W:0]     err_abs;
  logic               err_ok;

  // Datapath helpers: dwell limit, sweep direction, saturating PI arithmetic and lock tolerance test.
  always_comb begin
    dwell_last = (cps_q == '0) ? '0 : cps_q - CYC_W'(1);
    going_down = (mode_q == MODE_DOWN) || ((mode_q == MODE_TRI) && descend_q);

    err_ext = FREQ_W'($signed(phase_error));
    kp_term = err_ext << KP_SHIFT;
    ki_term = err_ext << KI_SHIFT;

    // One guard bit: overflow shows up as the two top bits disagreeing.
    integ_sum = {integ_q[FREQ_W-1], integ_q} + {ki_term[FREQ_W-1], ki_term};
    if (integ_sum[FREQ_W] != integ_sum[FREQ_W-1]) begin
      integ_sat = integ_sum[FREQ_W] ? {1'b1, {(FREQ_W-1){1'b0}}} : {1'b0, {(FREQ_W-1){1'b1}}};
    end else begin
      integ_sat = integ_sum[FREQ_W-1:0];
    end
    pi_freq = init_q + kp_term + integ_sat;

    // Extra bit so the magnitude of the most negative error is representable.
    err_sx  = {phase_error[ERR_W-1], phase_error};
    err_abs = err_sx[ERR_W] ? (~err_sx + (ERR_W+1)'(1)) : err_sx;
    err_ok  = (err_abs <= (ERR_W+1)'(LOCK_TOL));
  end

  // Next-state and next-output logic for the whole controller.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    init_d    = init_q;
    step_d    = step_q;
    dds_d     = dds_q;
    integ_d   = integ_q;
    cps_d     = cps_q;
    dwell_d   = dwell_q;
    nsteps_d  = nsteps_q;
    stepcnt_d = stepcnt_q;
    descend_d = descend_q;
    pcnt_d    = pcnt_q;
    good_d    = good_q;
    locked_d  = locked_q;
    upd_d     = 1'b0;
    start_d   = 1'b0;
    done_d    = 1'b0;

    if (abort && (state_q != S_IDLE)) begin
      // Abort wins over everything else; dds_freq is simply held.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (instr_valid && ready_q) begin
            mode_d   = instr_data[MODE_LSB +: 2];
            init_d   = instr_data[INIT_LSB +: FREQ_W];
            cps_d    = instr_data[CPS_LSB +: CYC_W];
            nsteps_d = instr_data[NS_LSB +: NSTEP_W];
            step_d   = instr_data[0 +: FREQ_W];
            state_d  = S_SETUP;
          end
        end
        S_SETUP: begin
          dds_d     = init_q;
          upd_d     = 1'b1;
          dwell_d   = '0;
          stepcnt_d = '0;
          descend_d = 1'b0;
          pcnt_d    = '0;
          good_d    = '0;
          if (mode_q == MODE_PLL) begin
            integ_d = '0;
            state_d = S_PLL_LOCK;
          end else begin
            start_d = 1'b1;
            state_d = S_SWEEP;
          end
        end
        S_SWEEP: begin
          if (dwell_q == dwell_last) begin
            dwell_d = '0;
            if (stepcnt_q == nsteps_q) begin
              if ((mode_q == MODE_TRI) && !descend_q && (nsteps_q != '0)) begin
                // Peak already dwelt on, so the descent starts one step below it.
                descend_d = 1'b1;
                stepcnt_d = NSTEP_W'(1);
                dds_d     = dds_q - step_q;
                upd_d     = 1'b1;
              end else begin
                done_d  = 1'b1;
                state_d = S_IDLE;
              end
            end else begin
              stepcnt_d = stepcnt_q + NSTEP_W'(1);
              dds_d     = going_down ? (dds_q - step_q) : (dds_q + step_q);
              upd_d     = 1'b1;
            end
          end else begin
            dwell_d = dwell_q + CYC_W'(1);
          end
        end
        S_PLL_LOCK: begin
          if (pcnt_q == PCNT_W'(LOCK_CYCLES - 1)) begin
            pcnt_d  = '0;
            state_d = S_PLL_TRACK;
          end else begin
            pcnt_d = pcnt_q + PCNT_W'(1);
          end
        end
        S_PLL_TRACK: begin
          if (pcnt_q == PCNT_W'(TRACK_DIV - 1)) begin
            pcnt_d  = '0;
            integ_d = integ_sat;
            dds_d   = pi_freq;
            upd_d   = 1'b1;
            if (err_ok) begin
              good_d   = (good_q == 3'd4) ? 3'd4 : good_q + 3'd1;
              locked_d = (good_q >= 3'd3);
            end else begin
              good_d   = '0;
              locked_d = 1'b0;
            end
          end else begin
            pcnt_d = pcnt_q + PCNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Lock history only has meaning while tracking.
    if (state_d != S_PLL_TRACK) begin
      good_d   = '0;
      locked_d = 1'b0;
    end

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    ena_d   = (state_d == S_PLL_LOCK) || (state_d == S_PLL_TRACK);
  end

  // State and registered outputs; reset clears everything, including instr_ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      init_q    <= '0;
      step_q    <= '0;
      dds_q     <= '0;
      integ_q   <= '0;
      cps_q     <= '0;
      dwell_q   <= '0;
      nsteps_q  <= '0;
      stepcnt_q <= '0;
      descend_q <= 1'b0;
      pcnt_q    <= '0;
      good_q    <= '0;
      upd_q     <= 1'b0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      ena_q     <= 1'b0;
      locked_q  <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      init_q    <= init_d;
      step_q    <= step_d;
      dds_q     <= dds_d;
      integ_q   <= integ_d;
      cps_q     <= cps_d;
      dwell_q   <= dwell_d;
      nsteps_q  <= nsteps_d;
      stepcnt_q <= stepcnt_d;
      descend_q <= descend_d;
      pcnt_q    <= pcnt_d;
      good_q    <= good_d;
      upd_q     <= upd_d;
      start_q   <= start_d;
      done_q    <= done_d;
      ena_q     <= ena_d;
      locked_q  <= locked_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  assign instr_ready = ready_q;
  assign dds_freq    = dds_q;
  assign freq_update = upd_q;
  assign sweep_start = start_q;
  assign sweep_done  = done_q;
  assign pll_enable  = ena_q;
  assign pll_locked  = locked_q;
  assign busy        = busy_q;

endmodule

// File: doc/freq_sweeper_gen2.md
Name: freq_sweeper_gen2

Overview:
Parametrised second-generation DDS frequency controller. Accepts one packed instruction per valid/ready handshake. Executes one of four modes: up sweep, down sweep, triangle sweep, or PLL tracking with a shift-based PI loop and lock detect. Sits between the instruction FIFO (first-word-fall-through) and the DDS tuning-word input. Supports abort at any time.

Parameters:
FREQ_W, 32, tuning-word width; all frequency arithmetic is modulo 2^FREQ_W
CYC_W, 16, dwell-counter width (cycles per step)
NSTEP_W, 12, step-count width
ERR_W, 16, signed phase-error width
KP_SHIFT, 3, proportional gain; term is sext(phase_error) <<< KP_SHIFT
KI_SHIFT, 1, integral gain; term is sext(phase_error) <<< KI_SHIFT
LOCK_CYCLES, 1024, settle time in PLL_LOCK, in cycles
TRACK_DIV, 16, cycles between PI updates
LOCK_TOL, 64, lock threshold on |phase_error|

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
instr_data  in  2+2*FREQ_W+CYC_W+NSTEP_W  packed as {mode[1:0], init_freq, cycles_per_step, num_steps, freq_step}, MSB first
instr_valid  in  1  FIFO has a word
instr_ready  out  1  block accepts a word; high only in IDLE
abort  in  1  level; forces return to IDLE
phase_error  in  ERR_W  signed phase-detector output
dds_freq  out  FREQ_W  current tuning word
freq_update  out  1  one-cycle pulse, concurrent with each new dds_freq value
sweep_start  out  1  one-cycle pulse at the first sweep frequency
sweep_done  out  1  one-cycle pulse at normal sweep completion
pll_enable  out  1  high in PLL_LOCK and PLL_TRACK
pll_locked  out  1  lock-detect flag
busy  out  1  high when state is not IDLE

Behaviour:
- Reset values: dds_freq=0, integrator=0, all pulses 0, pll_enable=0, pll_locked=0, busy=0, instr_ready=0. State=IDLE. instr_ready goes high on the first cycle after reset release.
- States: IDLE, SETUP, SWEEP, PLL_LOCK, PLL_TRACK.
- IDLE: instr_ready=1. An accept occurs when instr_valid & instr_ready are both high. On accept, all fields are captured and the next state is SETUP. abort is ignored in IDLE.
- SETUP (1 cycle): dds_freq<=init_freq and freq_update=1, both visible in the following cycle S.
  - Mode 00/01/10: sweep_start=1 in cycle S; go to SWEEP.
  - Mode 11: integrator<=0; go to PLL_LOCK.
- Dwell D = cycles_per_step, with 0 treated as 1. Each frequency is held for exactly D cycles.
- Mode 00: frequencies are init + k*step for k=0..num_steps.
- Mode 01: frequencies are init - k*step for k=0..num_steps.
- Mode 10: frequencies go up for num_steps steps, then down for num_steps steps, ending at init (2*num_steps+1 dwells).
- All sweep frequency additions and subtractions wrap modulo 2^FREQ_W.
- Sweep completion: in the cycle after the final dwell, sweep_done=1 and state=IDLE (instr_ready=1). dds_freq holds its last value.
- num_steps=0: init_freq is held for one dwell, then done. In mode 10 the direction reversal does not repeat the peak frequency.
- PLL_LOCK: dds_freq=init_freq for LOCK_CYCLES cycles, then go to PLL_TRACK.
- PLL_TRACK: every TRACK_DIV cycles, sample phase_error e, then:
  - I <= sat(I + (e<<<KI_SHIFT)). I is a signed FREQ_W accumulator that saturates at the signed min/max.
  - dds_freq <= init_freq + (e<<<KP_SHIFT) + I_new, wrapping; freq_update pulses with the new value.
- pll_locked:
  - Sets after 4 consecutive samples with |e| <= LOCK_TOL.
  - Clears on any sample with |e| > LOCK_TOL, and on leaving PLL_TRACK.
- PLL_TRACK runs until abort; no new instruction is accepted while in PLL mode.
- abort in a non-IDLE state: the next state is IDLE. No sweep_done is issued; pll_enable and pll_locked drop; dds_freq holds its value.
- Asynchronous reset mid-operation returns all outputs to their reset values immediately.

Test Plan:
- Up sweep, mode 00, init=1000, step=10, cps=3, nsteps=2 -> dds_freq is 1000/1010/1020 for 3 cycles each, freq_update pulses at each change, sweep_start pulses with 1000, sweep_done pulses in the cycle after the last 1020, instr_ready high that cycle.
- Triangle, mode 10, init=100, step=5, cps=1, nsteps=2 -> sequence 100,105,110,105,100, one cycle each, then sweep_done.
- Wrap: mode 01, init=5, step=10, nsteps=1 -> dds_freq goes 5 then 2^32-5; cps=0 behaves the same as cps=1.
- PLL, mode 11, init=0x10000, phase_error held at +4 -> pll_enable high for 1024 cycles at 0x10000; first update gives 0x10000+32+8; pll_locked asserts on the 4th sample. Step phase_error to 1000 -> pll_locked clears on the next sample.
- Integrator saturation: phase_error=+32767 held for many updates -> I clamps at 0x7FFFFFFF and does not wrap negative.
- abort during the 2nd sweep dwell, and again during PLL_TRACK -> IDLE next cycle, no sweep_done, dds_freq held. A back-to-back instruction with instr_valid high is accepted in the first IDLE cycle. reset_n low mid-sweep zeroes the outputs immediately.
